// File: rtl/dual_port_ram.sv
// True dual-port RAM, one clock, registered write-through outputs, synchronous active-low clear.
// Define DPR_BYPASS_EN to forward the other port's same-edge write data to a colliding read.
module dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic                  we_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    always_comb begin
        rd_a = mem[addr_a];
        rd_b = mem[addr_b];
`ifdef DPR_BYPASS_EN
        if (we_b && (addr_b == addr_a)) rd_a = data_b;
        if (we_a && (addr_a == addr_b)) rd_b = data_a;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem <= '{default: '0};
            q_a <= '0;
            q_b <= '0;
        end else begin
            // Port A's write is issued last so it wins a same-address collision.
            if (we_b) mem[addr_b] <= data_b;
            if (we_a) mem[addr_a] <= data_a;
            q_a <= we_a ? data_a : rd_a;
            q_b <= we_b ? data_b : rd_b;
        end
    end

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard bench for dual_port_ram: directed scenarios plus randomized traffic vs. an array model.
module tb_dual_port_ram;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data_a, data_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          we_a, we_b;
    logic [DW-1:0] q_a, q_b;

    dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_a(data_a), .addr_a(addr_a), .we_a(we_a), .q_a(q_a),
        .data_b(data_b), .addr_b(addr_b), .we_b(we_b), .q_b(q_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        string         name;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            total = 0;
    int            passed = 0;

`ifdef DPR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    endtask

    // Monitor: outputs are presented every cycle; sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, "_qa"}, q_a, e.a);
            check({e.name, "_qb"}, q_b, e.b);
        end
    end

    // Reference behaviour of one clock edge; returns the expected q values.
    task automatic model_edge(input logic r, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                              input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                              output logic [DW-1:0] ea, output logic [DW-1:0] eb);
        if (!r) begin
            foreach (ref_mem[i]) ref_mem[i] = '0;
            ea = '0;
            eb = '0;
            return;
        end
        if (wa) ea = da;
        else if (BYPASS && wb && ab == aa) ea = db;
        else ea = ref_mem[aa];
        if (wb) eb = db;
        else if (BYPASS && wa && aa == ab) eb = da;
        else eb = ref_mem[ab];
        if (wb && !(wa && aa == ab)) ref_mem[ab] = db;
        if (wa) ref_mem[aa] = da;
    endtask

    task automatic drive_edge(input logic r, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                              input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                              output logic [DW-1:0] ea, output logic [DW-1:0] eb);
        rst_n = r; we_a = wa; addr_a = aa; data_a = da; we_b = wb; addr_b = ab; data_b = db;
        @(posedge clk);
        model_edge(r, wa, aa, da, wb, ab, db, ea, eb);
    endtask

    // Directed step: expected values are the scenario constants, not the model's.
    task automatic dstep(input string name, input logic r,
                         input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                         input logic [DW-1:0] xa, input logic [DW-1:0] xb);
        logic [DW-1:0] ea, eb;
        exp_t e;
        drive_edge(r, wa, aa, da, wb, ab, db, ea, eb);
        e.a = xa; e.b = xb; e.name = name;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic rstep(input int n);
        logic [DW-1:0] ea, eb;
        logic          r, wa, wb;
        logic [AW-1:0] aa, ab;
        logic [DW-1:0] da, db;
        exp_t e;
        r  = ($urandom_range(39) != 0);
        wa = $urandom_range(1);
        wb = $urandom_range(1);
        aa = AW'($urandom_range(DEPTH - 1));
        ab = ($urandom_range(2) == 0) ? aa : AW'($urandom_range(DEPTH - 1));
        if ($urandom_range(7) == 0) aa = '1;
        if ($urandom_range(7) == 0) ab = '0;
        da = DW'($urandom);
        db = DW'($urandom);
        drive_edge(r, wa, aa, da, wb, ab, db, ea, eb);
        e.a = ea; e.b = eb; e.name = $sformatf("rnd%0d", n);
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;

        dstep("rst_wr",    0, 1, 6'h00, 8'hFF, 1, 6'h3F, 8'hEE, 8'h00, 8'h00);
        dstep("rst_idle",  0, 0, 6'h00, 8'h00, 0, 6'h00, 8'h00, 8'h00, 8'h00);
        dstep("rd_lo_hi",  1, 0, 6'h00, 8'h12, 0, 6'h3F, 8'h34, 8'h00, 8'h00);
        dstep("rd_hi_lo",  1, 0, 6'h3F, 8'h00, 0, 6'h00, 8'h00, 8'h00, 8'h00);
        dstep("wr_33_44",  1, 1, 6'h01, 8'h33, 1, 6'h02, 8'h44, 8'h33, 8'h44);
        dstep("wr55_rd01", 1, 1, 6'h03, 8'h55, 0, 6'h01, 8'h00, 8'h55, 8'h33);
        dstep("rd02_rd03", 1, 0, 6'h02, 8'h00, 0, 6'h03, 8'h00, 8'h44, 8'h55);
        dstep("rd01_wr77", 1, 0, 6'h01, 8'h00, 1, 6'h02, 8'h77, 8'h33, 8'h77);
        dstep("rd02_both", 1, 0, 6'h02, 8'h00, 0, 6'h02, 8'h00, 8'h77, 8'h77);
        dstep("ww_same",   1, 1, 6'h0A, 8'hAA, 1, 6'h0A, 8'hBB, 8'hAA, 8'hBB);
        dstep("rd_0a",     1, 0, 6'h0A, 8'h00, 0, 6'h0A, 8'h00, 8'hAA, 8'hAA);
        dstep("wr_11",     1, 1, 6'h10, 8'h11, 0, 6'h00, 8'h00, 8'h11, 8'h00);
        dstep("a_wr_b_rd", 1, 1, 6'h10, 8'h22, 0, 6'h10, 8'h00, 8'h22, BYPASS ? 8'h22 : 8'h11);
        dstep("rd_10",     1, 0, 6'h10, 8'h00, 0, 6'h10, 8'h00, 8'h22, 8'h22);
        dstep("b_wr_a_rd", 1, 0, 6'h10, 8'h00, 1, 6'h10, 8'h66, BYPASS ? 8'h66 : 8'h22, 8'h66);
        dstep("rd_10_b",   1, 0, 6'h10, 8'h00, 0, 6'h10, 8'h00, 8'h66, 8'h66);
        dstep("wr_edges",  1, 1, 6'h3F, 8'hFF, 1, 6'h00, 8'h01, 8'hFF, 8'h01);
        dstep("rd_edges",  1, 0, 6'h3F, 8'h00, 0, 6'h00, 8'h00, 8'hFF, 8'h01);
        dstep("rst_mid",   0, 1, 6'h3F, 8'h99, 1, 6'h00, 8'h98, 8'h00, 8'h00);
        dstep("post_rst",  1, 0, 6'h3F, 8'h00, 0, 6'h00, 8'h00, 8'h00, 8'h00);
        dstep("post_rst2", 1, 0, 6'h01, 8'h00, 0, 6'h02, 8'h00, 8'h00, 8'h00);
        dstep("post_rst3", 1, 0, 6'h10, 8'h00, 0, 6'h0A, 8'h00, 8'h00, 8'h00);

        for (int n = 0; n < 400; n++) rstep(n);

        we_a = 1'b0; we_b = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dual_port_ram.md
DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 Parameter DATA_WIDTH SHALL default to 8 and set the word width.
REQ-003 Parameter ADDR_WIDTH SHALL default to 6 and set the address width; depth = 2**ADDR_WIDTH (64).
REQ-004 Port clk SHALL be an input, 1 bit: the rising-edge clock for all state.
REQ-005 Port rst_n SHALL be an input, 1 bit: synchronous active-low reset.
REQ-006 Port data_a SHALL be an input, DATA_WIDTH bits: port A write data.
REQ-007 Port addr_a SHALL be an input, ADDR_WIDTH bits: port A address.
REQ-008 Port we_a SHALL be an input, 1 bit: port A write enable (1 = write, 0 = read).
REQ-009 Port q_a SHALL be an output, DATA_WIDTH bits: port A registered read data.
REQ-010 Port data_b SHALL be an input, DATA_WIDTH bits: port B write data.
REQ-011 Port addr_b SHALL be an input, ADDR_WIDTH bits: port B address.
REQ-012 Port we_b SHALL be an input, 1 bit: port B write enable.
REQ-013 Port q_b SHALL be an output, DATA_WIDTH bits: port B registered read data.

Function
REQ-014 Storage SHALL be one shared array of 2**ADDR_WIDTH words, visible to both ports.
REQ-015 Each port SHALL perform exactly one operation per rising clk edge, independent of the other port.
REQ-016 Write (we_x=1): mem[addr_x] <= data_x, and q_x <= data_x on the same edge (write-through).
REQ-017 Read (we_x=0): q_x <= mem[addr_x] as it was before the edge; read latency is 1 cycle.
REQ-018 q_a and q_b SHALL change only on a rising clk edge; no combinational path from inputs to outputs.
REQ-019 Both ports writing the same address on the same edge: port A's data SHALL be stored; each port's q still shows its own data_x.
REQ-020 One port reads an address the other port writes on the same edge: the reader SHALL get the old contents, unless DPR_BYPASS_EN is defined (REQ-026).
REQ-021 Both ports reading the same address SHALL both return the stored word.
REQ-022 Addresses SHALL be full-range with no wrap or out-of-range case; address 0 and address 2**ADDR_WIDTH-1 SHALL behave identically to all others.

Reset
REQ-023 While rst_n=0 at a rising edge: q_a and q_b SHALL become 0, every memory word SHALL become 0, and all writes SHALL be ignored.
REQ-024 Reset SHALL take priority over we_a/we_b on the same edge; the first edge with rst_n=1 SHALL perform normal operations.
REQ-025 Reset asserted mid-operation SHALL discard that edge's writes; the contents of any other word SHALL NOT survive reset.

Configuration
REQ-026 Macro DPR_BYPASS_EN: when defined, a read on one port of the address the other port writes on the same edge SHALL return that port's new data_x; when both ports write that address, the stored value is port A's, per REQ-019.
REQ-027 Without DPR_BYPASS_EN, the cross-port same-address read SHALL return the old contents (REQ-020); all other behaviour is identical with and without the macro.

Verification
REQ-028 Reset, then read addresses 0x00 and 0x3F on both ports -> q_a=q_b=0x00; writes with rst_n=0 leave the memory at 0.
REQ-029 Edge 1: A writes 0x33@0x01, B writes 0x44@0x02 -> q_a=0x33, q_b=0x44. Edge 2: A writes 0x55@0x03, B reads 0x01 -> q_a=0x55, q_b=0x33.
REQ-030 Following REQ-029: A reads 0x02 and B reads 0x03 -> q_a=0x44, q_b=0x55. Next edge: A reads 0x01, B writes 0x77@0x02 -> q_a=0x33, q_b=0x77. A then reads 0x02 -> 0x77.
REQ-031 Both ports write 0x0A: A data 0xAA, B data 0xBB -> q_a=0xAA, q_b=0xBB; a later read of 0x0A -> 0xAA.
REQ-032 With 0x10 holding 0x11, A writes 0x22@0x10 while B reads 0x10 -> q_b=0x11 without DPR_BYPASS_EN, 0x22 with it.
REQ-033 Write 0xFF@0x3F and 0x01@0x00, then read both addresses -> 0xFF and 0x01; assert rst_n mid-stream, then read both -> 0x00.
